hdlc_rx_line_monitor: RTL and testbench

Parametrised, synthesizable, multi-channel HDLC receive-line monitor. It carries the bit-level checks of the HDLC assertion bench into RTL: flag, abort, idle and zero-stuffing recognition, plus frame-length and alignment checking, for `CHANNELS` independent serial lines. It sits beside the Rx path and adds per-channel frame, error and abort counters, readable through a channel select. Each channel has its own state machine and runs independently of the others.

---
 rtl/hdlc_rx_line_monitor_if.sv | 33 +++
 rtl/hdlc_rx_line_monitor.sv | 160 ++++++++++++++++
 tb/tb_hdlc_rx_line_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_line_monitor_if.sv
// Bundle of serial lines, strobes, clear/select and monitor results for hdlc_rx_line_monitor.
interface hdlc_rx_line_monitor_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SIZE_W   = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SEL_W    = 2
);
  logic [CHANNELS-1:0]        Rx;
  logic [CHANNELS-1:0]        RxEN;
  logic                       Clear;
  logic [SEL_W-1:0]           Sel;
  logic [CHANNELS-1:0]        Rx_FlagDetect;
  logic [CHANNELS-1:0]        Rx_AbortDetect;
  logic [CHANNELS-1:0]        Rx_Idle;
  logic [CHANNELS-1:0]        Rx_FrameOk;
  logic [CHANNELS-1:0]        Rx_FrameErr;
  logic [CHANNELS*SIZE_W-1:0] Rx_FrameSize;
  logic [CNT_W-1:0]           FrameCnt;
  logic [CNT_W-1:0]           ErrCnt;
  logic [CNT_W-1:0]           AbortCnt;

  modport master (
    output Rx, RxEN, Clear, Sel,
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_Idle, Rx_FrameOk, Rx_FrameErr,
    input  Rx_FrameSize, FrameCnt, ErrCnt, AbortCnt
  );

  modport slave (
    input  Rx, RxEN, Clear, Sel,
    output Rx_FlagDetect, Rx_AbortDetect, Rx_Idle, Rx_FrameOk, Rx_FrameErr,
    output Rx_FrameSize, FrameCnt, ErrCnt, AbortCnt
  );
endinterface

// File: rtl/hdlc_rx_line_monitor.sv
// Multi-channel HDLC receive-line monitor: flag/abort/idle/stuffing recognition,
// frame length checking and per-channel saturating statistics counters.
module hdlc_rx_line_monitor #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned MAX_BYTES = 128,
  parameter int unsigned MIN_BYTES = 1,
  parameter int unsigned IDLE_LEN  = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  hdlc_rx_line_monitor_if.slave   bus
);
  localparam int unsigned SIZE_W  = $clog2(MAX_BYTES + 1);
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BIT_MAX = MAX_BYTES * 8 + 8;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned MUX_N   = 1 << SEL_W;

  typedef enum logic {HUNT = 1'b0, OPEN = 1'b1} state_t;

  logic [CHANNELS-1:0]        flag_v, abort_v, idle_v, ok_v, err_v;
  logic [CHANNELS*SIZE_W-1:0] size_v;
  logic [CNT_W-1:0]           frame_cnt [CHANNELS];
  logic [CNT_W-1:0]           err_cnt   [CHANNELS];
  logic [CNT_W-1:0]           abort_cnt [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t             state;
    logic [7:0]         ones;
    logic               armed;
    logic [BIT_W-1:0]   bitcnt;
    logic               flag_q, abort_q, idle_q, ok_q, err_q;
    logic [SIZE_W-1:0]  size_q;
    logic [CNT_W-1:0]   fcnt, ecnt, acnt;

    logic               rx_bit, en;
    logic [7:0]         ones_nxt;
    logic               is_flag, is_abort, is_stuff;
    logic [BIT_W-1:0]   payload;
    logic               len_ok, frame_ok_c, frame_err_c, abort_cnt_c;

    assign rx_bit   = bus.Rx[g];
    assign en       = bus.RxEN[g];
    assign ones_nxt = !rx_bit ? 8'd0 :
                      (ones >= 8'(IDLE_LEN)) ? ones : ones + 8'd1;
    assign is_flag  = armed && !rx_bit && (ones == 8'd6);
    assign is_abort = armed &&  rx_bit && (ones == 8'd6);
    assign is_stuff = (state == OPEN) && !rx_bit && (ones == 8'd5);
    // A flag sharing its zero with the previous one leaves bitcnt at 6; treat as empty.
    assign payload  = (bitcnt > BIT_W'(7)) ? bitcnt - BIT_W'(7) : '0;
    assign len_ok   = (payload[2:0] == 3'd0) &&
                      (payload >= BIT_W'(MIN_BYTES * 8)) &&
                      (payload <= BIT_W'(MAX_BYTES * 8));
    assign frame_ok_c  = en && is_flag && (state == OPEN) && (payload != '0) && len_ok;
    assign frame_err_c = en && is_flag && (state == OPEN) && (payload != '0) && !len_ok;
    assign abort_cnt_c = en && is_abort && (state == OPEN);

    // Per-channel bit tracker, framing FSM and registered event outputs.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        state   <= HUNT;
        ones    <= '0;
        armed   <= 1'b0;
        bitcnt  <= '0;
        flag_q  <= 1'b0;
        abort_q <= 1'b0;
        idle_q  <= 1'b0;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
        size_q  <= '0;
      end else begin
        flag_q  <= 1'b0;
        abort_q <= 1'b0;
        ok_q    <= frame_ok_c;
        err_q   <= frame_err_c;
        if (frame_ok_c) size_q <= SIZE_W'(payload >> 3);
        if (en) begin
          ones    <= ones_nxt;
          idle_q  <= (ones_nxt >= 8'(IDLE_LEN));
          flag_q  <= is_flag;
          abort_q <= is_abort;
          if (!rx_bit) armed <= 1'b1;
          case (state)
            HUNT: begin
              if (is_flag) begin
                state  <= OPEN;
                bitcnt <= '0;
              end
            end
            OPEN: begin
              if (is_abort) begin
                state <= HUNT;
              end else if (is_flag) begin
                bitcnt <= '0;
              end else if (!is_stuff && (bitcnt != BIT_W'(BIT_MAX))) begin
                bitcnt <= bitcnt + BIT_W'(1);
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end

    // Saturating statistics counters; Clear overrides any increment.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        fcnt <= '0;
        ecnt <= '0;
        acnt <= '0;
      end else if (bus.Clear) begin
        fcnt <= '0;
        ecnt <= '0;
        acnt <= '0;
      end else begin
        if (frame_ok_c  && (fcnt != {CNT_W{1'b1}})) fcnt <= fcnt + CNT_W'(1);
        if (frame_err_c && (ecnt != {CNT_W{1'b1}})) ecnt <= ecnt + CNT_W'(1);
        if (abort_cnt_c && (acnt != {CNT_W{1'b1}})) acnt <= acnt + CNT_W'(1);
      end
    end

    assign flag_v[g]                    = flag_q;
    assign abort_v[g]                   = abort_q;
    assign idle_v[g]                    = idle_q;
    assign ok_v[g]                      = ok_q;
    assign err_v[g]                     = err_q;
    assign size_v[g*SIZE_W +: SIZE_W]   = size_q;
    assign frame_cnt[g]                 = fcnt;
    assign err_cnt[g]                   = ecnt;
    assign abort_cnt[g]                 = acnt;
  end

  // Readout table padded with zeros for select values beyond the last channel.
  logic [CNT_W-1:0] frame_mux [MUX_N];
  logic [CNT_W-1:0] err_mux   [MUX_N];
  logic [CNT_W-1:0] abort_mux [MUX_N];

  for (genvar m = 0; m < MUX_N; m++) begin : g_mux
    if (m < CHANNELS) begin : g_live
      assign frame_mux[m] = frame_cnt[m];
      assign err_mux[m]   = err_cnt[m];
      assign abort_mux[m] = abort_cnt[m];
    end else begin : g_pad
      assign frame_mux[m] = '0;
      assign err_mux[m]   = '0;
      assign abort_mux[m] = '0;
    end
  end

  assign bus.Rx_FlagDetect  = flag_v;
  assign bus.Rx_AbortDetect = abort_v;
  assign bus.Rx_Idle        = idle_v;
  assign bus.Rx_FrameOk     = ok_v;
  assign bus.Rx_FrameErr    = err_v;
  assign bus.Rx_FrameSize   = size_v;
  assign bus.FrameCnt       = frame_mux[bus.Sel];
  assign bus.ErrCnt         = err_mux[bus.Sel];
  assign bus.AbortCnt       = abort_mux[bus.Sel];
endmodule

// File: tb/tb_hdlc_rx_line_monitor.sv
// Directed bench for hdlc_rx_line_monitor with hand-computed expectations.
module tb_hdlc_rx_line_monitor;
  localparam int unsigned CH     = 4;
  localparam int unsigned SIZE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SEL_W  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hdlc_rx_line_monitor_if #(.CHANNELS(CH), .SIZE_W(SIZE_W), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  hdlc_rx_line_monitor #(
    .CHANNELS(CH), .MAX_BYTES(128), .MIN_BYTES(1), .IDLE_LEN(15), .CNT_W(CNT_W)
  ) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one clock of inputs at the falling edge; outputs are settled at the next falling edge.
  task automatic step(input logic [CH-1:0] rx, input logic [CH-1:0] en, input logic clr);
    bus.Rx    = rx;
    bus.RxEN  = en;
    bus.Clear = clr;
    @(negedge clk);
  endtask

  task automatic send_bit(input int ch, input logic b, input logic clr);
    logic [CH-1:0] r;
    logic [CH-1:0] e;
    r = '0;
    e = '0;
    r[ch] = b;
    e[ch] = 1'b1;
    step(r, e, clr);
  endtask

  task automatic send_bits(input int ch, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(ch, v[i], 1'b0);
  endtask

  task automatic send_byte(input int ch, input logic [7:0] d, input logic clr_last);
    for (int i = 0; i < 8; i++) send_bit(ch, d[i], clr_last && (i == 7));
  endtask

  task automatic sel(input int s);
    bus.Sel = SEL_W'(s);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.Rx = '0; bus.RxEN = '0; bus.Clear = 1'b0; bus.Sel = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sel(0);
    check("rst_flag",  32'(bus.Rx_FlagDetect),  32'h0);
    check("rst_abort", 32'(bus.Rx_AbortDetect), 32'h0);
    check("rst_idle",  32'(bus.Rx_Idle),        32'h0);
    check("rst_ok",    32'(bus.Rx_FrameOk),     32'h0);
    check("rst_err",   32'(bus.Rx_FrameErr),    32'h0);
    check("rst_size",  32'(bus.Rx_FrameSize),   32'h0);
    check("rst_fcnt",  32'(bus.FrameCnt),       32'h0);
    check("rst_ecnt",  32'(bus.ErrCnt),         32'h0);
    check("rst_acnt",  32'(bus.AbortCnt),       32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // first flag on ch0: 0,1,1,1,1,1,1 then the closing 0
    send_bits(0, 16'h007E, 7);
    check("flag_early", 32'(bus.Rx_FlagDetect), 32'h0);
    send_bit(0, 1'b0, 1'b0);
    check("flag_pulse", 32'(bus.Rx_FlagDetect), 32'h1);
    check("flag_noabt", 32'(bus.Rx_AbortDetect), 32'h0);
    step('0, '0, 1'b0);
    check("flag_one_cycle", 32'(bus.Rx_FlagDetect), 32'h0);

    // two-byte frame 0xA5 0x3C
    send_byte(0, 8'hA5, 1'b0);
    send_byte(0, 8'h3C, 1'b0);
    send_byte(0, 8'h7E, 1'b0);
    check("f2_ok",   32'(bus.Rx_FrameOk),        32'h1);
    check("f2_err",  32'(bus.Rx_FrameErr),       32'h0);
    check("f2_size", 32'(bus.Rx_FrameSize[7:0]), 32'd2);
    check("f2_fcnt", 32'(bus.FrameCnt),          32'd1);

    // 0xFF with a stuffed zero after the fifth one
    send_bits(0, 16'h01DF, 9);
    send_byte(0, 8'h7E, 1'b0);
    check("stuff_ok",   32'(bus.Rx_FrameOk),        32'h1);
    check("stuff_size", 32'(bus.Rx_FrameSize[7:0]), 32'd1);
    check("stuff_fcnt", 32'(bus.FrameCnt),          32'd2);
    check("stuff_ecnt", 32'(bus.ErrCnt),            32'd0);

    // 13-bit payload is misaligned
    send_bits(0, 16'h1555, 13);
    send_byte(0, 8'h7E, 1'b0);
    check("odd_err",  32'(bus.Rx_FrameErr),       32'h1);
    check("odd_ok",   32'(bus.Rx_FrameOk),        32'h0);
    check("odd_size", 32'(bus.Rx_FrameSize[7:0]), 32'd1);
    check("odd_ecnt", 32'(bus.ErrCnt),            32'd1);

    // exactly MAX_BYTES is legal
    for (int i = 0; i < 128; i++) send_byte(0, 8'h00, 1'b0);
    send_byte(0, 8'h7E, 1'b0);
    check("max_ok",   32'(bus.Rx_FrameOk),        32'h1);
    check("max_size", 32'(bus.Rx_FrameSize[7:0]), 32'd128);
    check("max_fcnt", 32'(bus.FrameCnt),          32'd3);

    // 130 bytes overflows
    for (int i = 0; i < 130; i++) send_byte(0, 8'h00, 1'b0);
    send_byte(0, 8'h7E, 1'b0);
    check("ovf_err",  32'(bus.Rx_FrameErr),       32'h1);
    check("ovf_ok",   32'(bus.Rx_FrameOk),        32'h0);
    check("ovf_ecnt", 32'(bus.ErrCnt),            32'd2);
    check("ovf_fcnt", 32'(bus.FrameCnt),          32'd3);
    check("ovf_size", 32'(bus.Rx_FrameSize[7:0]), 32'd128);

    // back-to-back flag: empty payload, no frame event
    send_byte(0, 8'h7E, 1'b0);
    check("b2b_flag", 32'(bus.Rx_FlagDetect), 32'h1);
    check("b2b_ok",   32'(bus.Rx_FrameOk),    32'h0);
    check("b2b_err",  32'(bus.Rx_FrameErr),   32'h0);

    // ch2: open, some data, then abort
    send_byte(2, 8'h7E, 1'b0);
    check("c2_flag", 32'(bus.Rx_FlagDetect), 32'h4);
    send_bits(2, 16'h0005, 3);
    send_bits(2, 16'h007E, 7);
    check("c2_pre_abort", 32'(bus.Rx_AbortDetect), 32'h0);
    send_bit(2, 1'b1, 1'b0);
    check("c2_abort", 32'(bus.Rx_AbortDetect), 32'h4);
    sel(2);
    check("c2_acnt", 32'(bus.AbortCnt), 32'd1);
    sel(0);
    check("c0_acnt", 32'(bus.AbortCnt), 32'd0);
    send_byte(2, 8'h7E, 1'b0);
    check("c2_reflag", 32'(bus.Rx_FlagDetect), 32'h4);
    check("c2_no_ok",  32'(bus.Rx_FrameOk),    32'h0);
    check("c2_no_err", 32'(bus.Rx_FrameErr),   32'h0);

    // ch3: unarmed ones never abort; abort in HUNT is not counted
    send_bits(3, 16'h007F, 7);
    check("c3_unarmed", 32'(bus.Rx_AbortDetect), 32'h0);
    send_bits(3, 16'h00FE, 8);
    check("c3_hunt_abort", 32'(bus.Rx_AbortDetect), 32'h8);
    sel(3);
    check("c3_acnt", 32'(bus.AbortCnt), 32'd0);
    sel(0);

    // ch1 idle detection
    send_bits(1, 16'h3FFF, 14);
    check("idle_14", 32'(bus.Rx_Idle), 32'h0);
    send_bit(1, 1'b1, 1'b0);
    check("idle_15", 32'(bus.Rx_Idle), 32'h2);
    step('0, '0, 1'b0);
    check("idle_hold", 32'(bus.Rx_Idle), 32'h2);
    send_bit(1, 1'b0, 1'b0);
    check("idle_clear", 32'(bus.Rx_Idle), 32'h0);

    // Clear coinciding with a good frame on ch0
    send_byte(0, 8'hA5, 1'b0);
    send_byte(0, 8'h7E, 1'b1);
    bus.Clear = 1'b0;
    check("clr_ok",   32'(bus.Rx_FrameOk),        32'h1);
    check("clr_size", 32'(bus.Rx_FrameSize[7:0]), 32'd1);
    check("clr_fcnt", 32'(bus.FrameCnt),          32'd0);
    check("clr_ecnt", 32'(bus.ErrCnt),            32'd0);
    sel(2);
    check("clr_c2_acnt", 32'(bus.AbortCnt), 32'd0);
    sel(0);
    send_byte(0, 8'h3C, 1'b0);
    send_byte(0, 8'h7E, 1'b0);
    check("post_clr_fcnt", 32'(bus.FrameCnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
